// File: rtl/sram_arbiter.sv
// Round-robin owner arbiter for the shared main-memory SRAM port; muxes the owner's bundle onto the pins.
// Define SRAM_ARB_PREEMPT_EN to enable the MAX_HOLD tenure timeout and preempted pulses.
module sram_arbiter #(
    parameter int unsigned NUM_REQ        = 2,
    parameter int unsigned ADDR_BUS_WIDTH = 64,
    parameter int unsigned DATA_BUS_WIDTH = 64,
    parameter int unsigned MAX_HOLD       = 16
) (
    input  logic                                     clk,
    input  logic                                     rst_n,
    input  logic [NUM_REQ-1:0]                       req,
    output logic [NUM_REQ-1:0]                       grant,
    output logic [NUM_REQ-1:0]                       preempted,
    input  logic [NUM_REQ-1:0]                       req_CEN,
    input  logic [NUM_REQ-1:0]                       req_GWEN,
    input  logic [NUM_REQ-1:0][ADDR_BUS_WIDTH-1:0]   req_A,
    input  logic [NUM_REQ-1:0][DATA_BUS_WIDTH-1:0]   req_D,
    output logic [DATA_BUS_WIDTH-1:0]                rsp_Q,
    output logic [NUM_REQ-1:0]                       rsp_valid,
    output logic                                     mem_sram_CEN,
    output logic                                     mem_sram_GWEN,
    output logic [ADDR_BUS_WIDTH-1:0]                mem_sram_A,
    output logic [DATA_BUS_WIDTH-1:0]                mem_sram_D,
    input  logic [DATA_BUS_WIDTH-1:0]                mem_sram_Q
);

    localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    if (MAX_HOLD < 2) begin : g_bad_hold
        $error("sram_arbiter: MAX_HOLD must be >= 2");
    end

    typedef enum logic {S_IDLE, S_GRANT} state_t;

    state_t             r_state;
    state_t             w_next_state;
    logic [NUM_REQ-1:0] r_grant;
    logic [NUM_REQ-1:0] w_next_grant;
    logic [IDX_W-1:0]   r_last_owner;
    logic [IDX_W-1:0]   w_next_last_owner;
    logic [IDX_W-1:0]   w_idx;
    logic [IDX_W-1:0]   w_win;
    logic               w_found;
    logic               w_preempt;
    logic               w_own;
    logic               r_rd_pend;
    logic [IDX_W-1:0]   r_rd_tag;

`ifdef SRAM_ARB_PREEMPT_EN
    localparam int unsigned HOLD_W = $clog2(MAX_HOLD);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);
    logic [HOLD_W-1:0]  r_hold_cnt;
    logic [NUM_REQ-1:0] r_preempted;
`endif

    // Round-robin search starting after the last owner, so the ex-owner is considered last
    always_comb begin
        w_found = 1'b0;
        w_win   = r_last_owner;
        w_idx   = r_last_owner;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            w_idx = IDX_W'((32'(r_last_owner) + k) % NUM_REQ);
            if (!w_found && req[w_idx]) begin
                w_found = 1'b1;
                w_win   = w_idx;
            end
        end
    end

    // Next-state and next-grant logic
    always_comb begin
        w_next_state      = r_state;
        w_next_grant      = r_grant;
        w_next_last_owner = r_last_owner;
        w_preempt         = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_next_state      = S_GRANT;
                    w_next_grant      = NUM_REQ'(1) << w_win;
                    w_next_last_owner = w_win;
                end
            end
            S_GRANT: begin
                if (!req[r_last_owner]) begin
                    w_next_state = S_IDLE;
                    w_next_grant = '0;
                end
`ifdef SRAM_ARB_PREEMPT_EN
                else if (r_hold_cnt == HOLD_LAST && (req & ~r_grant) != '0) begin
                    w_next_state = S_IDLE;
                    w_next_grant = '0;
                    w_preempt    = 1'b1;
                end
`endif
            end
            default: begin
                w_next_state = S_IDLE;
                w_next_grant = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_grant      <= '0;
            r_last_owner <= IDX_W'(NUM_REQ - 1);
            r_rd_pend    <= 1'b0;
            r_rd_tag     <= '0;
        end else begin
            r_state      <= w_next_state;
            r_grant      <= w_next_grant;
            r_last_owner <= w_next_last_owner;
            r_rd_pend    <= w_own & ~req_CEN[r_last_owner] & req_GWEN[r_last_owner];
            r_rd_tag     <= r_last_owner;
        end
    end

`ifdef SRAM_ARB_PREEMPT_EN
    // Tenure counter restarts on every fresh grant and saturates at the expiry value
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_hold_cnt  <= '0;
            r_preempted <= '0;
        end else begin
            if (r_state == S_IDLE) begin
                r_hold_cnt <= '0;
            end else if (r_hold_cnt != HOLD_LAST) begin
                r_hold_cnt <= r_hold_cnt + HOLD_W'(1);
            end
            r_preempted <= w_preempt ? r_grant : '0;
        end
    end
    assign preempted = r_preempted;
`else
    assign preempted = '0;
`endif

    assign grant = r_grant;
    assign w_own = (r_state == S_GRANT);

    // SRAM pins follow the owner's bundle only while a grant is active
    always_comb begin
        mem_sram_CEN  = 1'b1;
        mem_sram_GWEN = 1'b1;
        mem_sram_A    = '0;
        mem_sram_D    = '0;
        if (w_own) begin
            mem_sram_CEN  = req_CEN[r_last_owner];
            mem_sram_GWEN = req_GWEN[r_last_owner];
            mem_sram_A    = req_A[r_last_owner];
            mem_sram_D    = req_D[r_last_owner];
        end
    end

    always_comb begin
        rsp_valid           = '0;
        rsp_valid[r_rd_tag] = r_rd_pend;
        rsp_Q               = r_rd_pend ? mem_sram_Q : '0;
    end

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter; expectations follow SRAM_ARB_PREEMPT_EN when defined.
module tb_sram_arbiter;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [1:0]       req;
    logic [1:0]       grant;
    logic [1:0]       preempted;
    logic [1:0]       req_CEN;
    logic [1:0]       req_GWEN;
    logic [1:0][63:0] req_A;
    logic [1:0][63:0] req_D;
    logic [63:0]      rsp_Q;
    logic [1:0]       rsp_valid;
    logic             mem_sram_CEN;
    logic             mem_sram_GWEN;
    logic [63:0]      mem_sram_A;
    logic [63:0]      mem_sram_D;
    logic [63:0]      mem_sram_Q;

    int n_vec = 0;
    int n_err = 0;

    sram_arbiter #(
        .NUM_REQ(2), .ADDR_BUS_WIDTH(64), .DATA_BUS_WIDTH(64), .MAX_HOLD(16)
    ) u_dut (
        .clk(clk), .rst_n(rst_n), .req(req), .grant(grant), .preempted(preempted),
        .req_CEN(req_CEN), .req_GWEN(req_GWEN), .req_A(req_A), .req_D(req_D),
        .rsp_Q(rsp_Q), .rsp_valid(rsp_valid),
        .mem_sram_CEN(mem_sram_CEN), .mem_sram_GWEN(mem_sram_GWEN),
        .mem_sram_A(mem_sram_A), .mem_sram_D(mem_sram_D), .mem_sram_Q(mem_sram_Q)
    );

    always #5 clk = ~clk;

    // SRAM model: 0x40 holds 0xDEAD, other addresses read A^0xA5A5; non-read cycles return junk
    always @(posedge clk) begin
        if (!mem_sram_CEN && mem_sram_GWEN)
            mem_sram_Q <= (mem_sram_A == 64'h40) ? 64'hDEAD : (mem_sram_A ^ 64'hA5A5);
        else
            mem_sram_Q <= 64'hBAD0;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    initial begin
        logic [1:0] exp_g;
        logic [1:0] exp_p;
        rst_n    = 1'b0;
        req      = 2'b11;
        req_CEN  = 2'b11;
        req_GWEN = 2'b11;
        req_A    = '0;
        req_D    = '0;

        // Reset held 3 cycles with both requests up
        step(3);
        chk("rst_grant", 64'(grant), 64'h0);
        chk("rst_preempted", 64'(preempted), 64'h0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'h0);
        chk("rst_rsp_Q", rsp_Q, 64'h0);
        chk("rst_CEN", 64'(mem_sram_CEN), 64'h1);
        chk("rst_GWEN", 64'(mem_sram_GWEN), 64'h1);
        chk("rst_A", mem_sram_A, 64'h0);
        chk("rst_D", mem_sram_D, 64'h0);
        rst_n = 1'b1;
        step(1);
        chk("first_grant", 64'(grant), 64'h1);

        // Owner 0 read then write
        req_CEN[0] = 1'b0; req_GWEN[0] = 1'b1; req_A[0] = 64'h40;
        #1;
        chk("rd_CEN", 64'(mem_sram_CEN), 64'h0);
        chk("rd_A", mem_sram_A, 64'h40);
        step(1);
        chk("rd_rsp_valid", 64'(rsp_valid), 64'h1);
        chk("rd_rsp_Q", rsp_Q, 64'hDEAD);
        req_GWEN[0] = 1'b0; req_A[0] = 64'h48; req_D[0] = 64'h1234;
        #1;
        chk("wr_GWEN", 64'(mem_sram_GWEN), 64'h0);
        chk("wr_D", mem_sram_D, 64'h1234);
        step(1);
        chk("wr_no_rsp", 64'(rsp_valid), 64'h0);
        chk("wr_rsp_Q_zero", rsp_Q, 64'h0);

        // Requester 1 drives a read while not granted
        req_CEN[0] = 1'b1; req_GWEN[0] = 1'b1; req_A[0] = '0; req_D[0] = '0;
        req_CEN[1] = 1'b0; req_GWEN[1] = 1'b1; req_A[1] = 64'h99;
        #1;
        chk("iso_CEN", 64'(mem_sram_CEN), 64'h1);
        chk("iso_A", mem_sram_A, 64'h0);
        step(1);
        chk("iso_no_rsp", 64'(rsp_valid), 64'h0);

        // Handover: owner 0 drops, re-raises in the idle cycle and must lose to 1
        req[0] = 1'b0;
        step(1);
        chk("ho_idle_grant", 64'(grant), 64'h0);
        req[0] = 1'b1;
        step(1);
        chk("rr_grant1", 64'(grant), 64'h2);
        chk("rr_A1", mem_sram_A, 64'h99);
        step(1);
        chk("rr_rsp_valid1", 64'(rsp_valid), 64'h2);
        chk("rr_rsp_Q1", rsp_Q, 64'hA53C);
        req_CEN[1] = 1'b1;
        step(2);
        chk("rr_hold1", 64'(grant), 64'h2);
        req[1] = 1'b0;
        step(1);
        chk("rr_idle2", 64'(grant), 64'h0);
        req[1] = 1'b1;
        step(1);
        chk("rr_grant0", 64'(grant), 64'h1);

        // Read on the final granted cycle still returns after release
        req_CEN[0] = 1'b0; req_GWEN[0] = 1'b1; req_A[0] = 64'h40;
        req = 2'b00;
        step(1);
        chk("infl_grant", 64'(grant), 64'h0);
        chk("infl_rsp_valid", 64'(rsp_valid), 64'h1);
        chk("infl_rsp_Q", rsp_Q, 64'hDEAD);
        chk("infl_CEN_idle", 64'(mem_sram_CEN), 64'h1);
        req_CEN[0] = 1'b1;

        // Long tenure by owner 0 with requester 1 arriving in its second cycle
        req = 2'b01;
        step(1);
        for (int c = 1; c <= 20; c++) begin
            if (c == 2) req[1] = 1'b1;
`ifdef SRAM_ARB_PREEMPT_EN
            exp_g = (c <= 16) ? 2'b01 : (c == 17) ? 2'b00 : 2'b10;
            exp_p = (c == 17) ? 2'b01 : 2'b00;
`else
            exp_g = 2'b01;
            exp_p = 2'b00;
`endif
            chk($sformatf("hold_grant_c%0d", c), 64'(grant), 64'(exp_g));
            chk($sformatf("hold_preempted_c%0d", c), 64'(preempted), 64'(exp_p));
            step(1);
        end

        // Synchronous reset mid-tenure with reads in flight
        req_CEN = 2'b00; req_GWEN = 2'b11; req_A[0] = 64'h40; req_A[1] = 64'h40;
        rst_n = 1'b0;
        step(1);
        chk("mrst_grant", 64'(grant), 64'h0);
        chk("mrst_rsp_valid", 64'(rsp_valid), 64'h0);
        chk("mrst_CEN", 64'(mem_sram_CEN), 64'h1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/sram_arbiter.md
# sram_arbiter

Round-robin arbiter and port sequencer that shares the single main-memory SRAM port between the octree requesters (searcher, updater, and any later masters). It replaces the static mode-select mux at the top level: requesters raise `req`, receive a registered `grant`, drive the SRAM for as long as they hold it, and get read data back tagged with a per-requester `rsp_valid`. It sits between the octree engines and the SRAM macro, and is the only driver of the SRAM pins.

## Interface
- `NUM_REQ`, 2: number of requesters. Index 0 is the searcher, index 1 the updater.
- `ADDR_BUS_WIDTH`, 64: SRAM address width.
- `DATA_BUS_WIDTH`, 64: SRAM data width.
- `MAX_HOLD`, 16: maximum grant tenure in cycles when preemption is compiled in. Must be ≥2.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, synchronous and active-low.
- `req`  in  NUM_REQ  per-requester ownership request, level, held while ownership is wanted.
- `grant`  out  NUM_REQ  one-hot-or-zero registered grant.
- `preempted`  out  NUM_REQ  1-cycle pulse to the owner whose grant was revoked by timeout.
- `req_CEN`  in  NUM_REQ  per-requester chip enable, active-low.
- `req_GWEN`  in  NUM_REQ  per-requester write enable: 0 write, 1 read.
- `req_A`  in  NUM_REQ×ADDR_BUS_WIDTH  per-requester address.
- `req_D`  in  NUM_REQ×DATA_BUS_WIDTH  per-requester write data.
- `rsp_Q`  out  DATA_BUS_WIDTH  read data, broadcast to all requesters.
- `rsp_valid`  out  NUM_REQ  `rsp_Q` is valid for requester i.
- `mem_sram_CEN`, `mem_sram_GWEN`  out  1  SRAM controls.
- `mem_sram_A`  out  ADDR_BUS_WIDTH  SRAM address.
- `mem_sram_D`  out  DATA_BUS_WIDTH  SRAM write data.
- `mem_sram_Q`  in  DATA_BUS_WIDTH  SRAM read data, valid 1 cycle after a read.

## Operation
- **FSM states:** IDLE, GRANT.
- **IDLE:**
  - If any `req` bit is set, pick the winner by round-robin, searching from `last_owner+1` mod NUM_REQ.
  - Register `grant[winner]`, set `last_owner=winner`, clear `hold_cnt`, go to GRANT.
- **GRANT:**
  - The SRAM pins combinationally follow the owner's `req_*` bundle.
  - `hold_cnt` increments and saturates at MAX_HOLD-1.
  - **Release:** owner `req`=0 → `grant` cleared next edge, go to IDLE.
  - **Preempt:** only with the macro enabled, and only when `hold_cnt==MAX_HOLD-1` and another `req` is pending. `grant` is cleared next edge, `preempted[owner]` pulses in that same next cycle, go to IDLE.
- **No grant:** `mem_sram_CEN=1`, `GWEN=1`, `A=0`, `D=0`. Requester bundles without grant are ignored.
- **Read return:**
  - Register `rd_tag` = owner index and `rd_pend` = (grant & !CEN & GWEN).
  - Next cycle `rsp_valid[rd_tag]=rd_pend`, and `rsp_Q=mem_sram_Q` when `rd_pend`, else 0.
  - The return is delivered even if grant has since dropped.
- **Writes:** produce no response.
- **Simultaneous events:**
  - Owner dropping `req` on the expiry cycle is a normal release: no `preempted`.
  - An ex-owner re-requesting in IDLE loses to any other pending requester.

## Timing
- **Reset values:** `grant=0`, `preempted=0`, `rsp_valid=0`, `rsp_Q=0`, SRAM outputs idle (CEN=1, GWEN=1, A=0, D=0). `last_owner=NUM_REQ-1`, so requester 0 wins first. State is IDLE.
- **Arbitration latency:** `req` sampled at edge n → `grant` high in cycle n+1. The first SRAM access is the cycle n+1 bundle.
- **Handover:** owner `req` low at edge m → grant low in m+1 (IDLE) → next grant in m+2. One dead cycle per handover.
- **Grant state:** `grant` changes only on edges; it never glitches within a cycle.
- **Access rule:** an access counts only in a cycle where that requester's `grant` is high. On preemption the owner must re-request and reissue accesses not performed.
- **Read data:** `rsp_valid` and `rsp_Q` are 1 cycle after the read cycle.
- **Reset mid-tenure:** synchronous reset drops `grant` and any pending `rsp_valid` on the next edge. No response is delivered.

## Configuration
- `SRAM_ARB_PREEMPT_EN`
  - **Defined:** the `hold_cnt` timeout and `preempted` pulses are active.
  - **Undefined:** the owner keeps the grant until it drops `req`; `preempted` is tied to 0; `hold_cnt` logic is removed.

## Test plan
- **Reset:** hold `rst_n`=0 for 3 cycles with `req`=2'b11 → all outputs at reset values. Release reset → `grant`=2'b01 one cycle later.
- **Read return:** owner 0 reads A=0x40, SRAM returns 0xDEAD → `rsp_valid`=2'b01 and `rsp_Q`=0xDEAD next cycle. A write to A=0x48 D=0x1234 → `mem_sram_GWEN`=0, D=0x1234, and no `rsp_valid`.
- **Round-robin:** `req`=2'b11 held, each owner drops `req` after 4 cycles then re-raises → grants alternate 01, 10, 01 with one idle cycle between.
- **Non-owner isolation:** requester 1 drives CEN=0 A=0x99 while not granted → `mem_sram_CEN` stays 1 and A=0.
- **Preemption (macro on):** owner 0 holds 20 cycles and req[1] rises at cycle 2 → grant 0 drops after 16 cycles, `preempted`=2'b01 pulse, grant=2'b10 one cycle later.
- **Preemption (macro off):** same stimulus → grant 0 holds all 20 cycles, `preempted` stays 0.
- **Read in flight at release:** last read issued on the final granted cycle → `rsp_valid[0]` still asserts the following cycle while `grant`=0.
